// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake, flush, optional
// 2-entry skid buffer, writeback select and forwarding tap.
module memwb_pipe_reg #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int RWIDTH = 5,
    parameter int IWIDTH = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        memtoregin,
    input  logic              regwrin,
    input  logic              finin,
    input  logic [RWIDTH-1:0] regdstmuxin,
    input  logic [DWIDTH-1:0] aluoutin,
    input  logic [DWIDTH-1:0] dmdatain,
    input  logic [AWIDTH-1:0] pcnextin,
    input  logic              negativein,
    input  logic [IWIDTH-1:0] insin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        memtoregout,
    output logic              regwrout,
    output logic              finout,
    output logic [RWIDTH-1:0] regdstmuxout,
    output logic [DWIDTH-1:0] aluoutout,
    output logic [DWIDTH-1:0] dmdataout,
    output logic [AWIDTH-1:0] pcnextout,
    output logic              negativeout,
    output logic [IWIDTH-1:0] insout,
    output logic [DWIDTH-1:0] wbdata,
    output logic              fwd_en,
    output logic [RWIDTH-1:0] fwd_reg,
    output logic [DWIDTH-1:0] fwd_data,
    output logic [1:0]        count
);

    typedef struct packed {
        logic [1:0]        memtoreg;
        logic              regwr;
        logic              fin;
        logic [RWIDTH-1:0] regdst;
        logic [DWIDTH-1:0] aluout;
        logic [DWIDTH-1:0] dmdata;
        logic [AWIDTH-1:0] pcnext;
        logic              negative;
        logic [IWIDTH-1:0] ins;
    } ent_t;

    ent_t in_e;
    ent_t head_q;
    logic head_v;
    logic skid_v;
    logic acc;
    logic cons;

    assign in_e = '{
        memtoreg: memtoregin,
        regwr:    regwrin,
        fin:      finin,
        regdst:   regdstmuxin,
        aluout:   aluoutin,
        dmdata:   dmdatain,
        pcnext:   pcnextin,
        negative: negativein,
        ins:      insin
    };

    assign acc  = in_valid & in_ready;
    assign cons = head_v & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            ent_t skid_q;
            logic sv;

            assign skid_v   = sv;
            assign in_ready = !sv;

            // Head/skid pair: skid only fills while the head is stalled,
            // and always drains into the head first to keep FIFO order.
            always_ff @(posedge clk) begin
                if (rst) begin
                    head_v <= 1'b0;
                    sv     <= 1'b0;
                    head_q <= '0;
                    skid_q <= '0;
                end else if (flush) begin
                    head_v <= 1'b0;
                    sv     <= 1'b0;
                end else if (cons) begin
                    if (sv) begin
                        head_q <= skid_q;
                        sv     <= 1'b0;
                    end else if (acc) begin
                        head_q <= in_e;
                    end else begin
                        head_v <= 1'b0;
                    end
                end else if (acc) begin
                    if (!head_v) begin
                        head_q <= in_e;
                        head_v <= 1'b1;
                    end else begin
                        skid_q <= in_e;
                        sv     <= 1'b1;
                    end
                end
            end
        end else begin : g_single
            assign skid_v   = 1'b0;
            assign in_ready = !head_v | out_ready;

            // Single entry: a same-cycle consume and accept replaces the
            // head so streaming runs without a bubble.
            always_ff @(posedge clk) begin
                if (rst) begin
                    head_v <= 1'b0;
                    head_q <= '0;
                end else if (flush) begin
                    head_v <= 1'b0;
                end else if (acc) begin
                    head_q <= in_e;
                    head_v <= 1'b1;
                end else if (cons) begin
                    head_v <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid    = head_v;
    assign memtoregout  = head_q.memtoreg;
    assign regwrout     = head_q.regwr;
    assign finout       = head_q.fin;
    assign regdstmuxout = head_q.regdst;
    assign aluoutout    = head_q.aluout;
    assign dmdataout    = head_q.dmdata;
    assign pcnextout    = head_q.pcnext;
    assign negativeout  = head_q.negative;
    assign insout       = head_q.ins;

    // Writeback word selected from the head entry only.
    always_comb begin
        wbdata = '0;
        unique case (head_q.memtoreg)
            2'b00:   wbdata = head_q.aluout;
            2'b01:   wbdata = head_q.dmdata;
            2'b10:   wbdata = DWIDTH'(head_q.pcnext);
            default: wbdata = DWIDTH'(head_q.negative);
        endcase
    end

    assign fwd_en   = head_v & head_q.regwr & (head_q.regdst != '0);
    assign fwd_reg  = head_q.regdst;
    assign fwd_data = wbdata;

    assign count = {1'b0, head_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Randomized scoreboard bench for memwb_pipe_reg, run with SKID=1 and
// SKID=0 side by side against a queue-based reference model.
module tb_memwb_pipe_reg;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int IW = 32;
    localparam int NCYC = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int done    = 0;

    typedef struct {
        logic [1:0]    m2r;
        logic          rw;
        logic          fin;
        logic [RW-1:0] rd;
        logic [DW-1:0] alu;
        logic [DW-1:0] dm;
        logic [AW-1:0] pc;
        logic          neg;
        logic [IW-1:0] ins;
    } ent_t;

    function automatic logic [DW-1:0] exp_wb(ent_t e);
        case (e.m2r)
            2'd0:    return e.alu;
            2'd1:    return e.dm;
            2'd2:    return e.pc;
            default: return {31'd0, e.neg};
        endcase
    endfunction

    task automatic chk(string nm, int sk, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s skid=%0d t=%0t got=%h want=%h",
                     nm, sk, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int SK = (g == 0) ? 1 : 0;

        logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
        logic [1:0]    memtoregin, memtoregout, count;
        logic          regwrin, regwrout, finin, finout;
        logic          negativein, negativeout, fwd_en;
        logic [RW-1:0] regdstmuxin, regdstmuxout, fwd_reg;
        logic [DW-1:0] aluoutin, aluoutout, dmdatain, dmdataout;
        logic [DW-1:0] wbdata, fwd_data;
        logic [AW-1:0] pcnextin, pcnextout;
        logic [IW-1:0] insin, insout;

        memwb_pipe_reg #(
            .DWIDTH(DW), .AWIDTH(AW), .RWIDTH(RW),
            .IWIDTH(IW), .SKID(SK)
        ) dut (
            .clk(clk), .rst(rst), .flush(flush),
            .in_valid(in_valid), .in_ready(in_ready),
            .memtoregin(memtoregin), .regwrin(regwrin),
            .finin(finin), .regdstmuxin(regdstmuxin),
            .aluoutin(aluoutin), .dmdatain(dmdatain),
            .pcnextin(pcnextin), .negativein(negativein),
            .insin(insin),
            .out_valid(out_valid), .out_ready(out_ready),
            .memtoregout(memtoregout), .regwrout(regwrout),
            .finout(finout), .regdstmuxout(regdstmuxout),
            .aluoutout(aluoutout), .dmdataout(dmdataout),
            .pcnextout(pcnextout), .negativeout(negativeout),
            .insout(insout), .wbdata(wbdata),
            .fwd_en(fwd_en), .fwd_reg(fwd_reg),
            .fwd_data(fwd_data), .count(count)
        );

        ent_t q[$];
        ent_t pend;
        logic acc_pend;
        logic zero_ok = 1'b0;

        // Driver: new inputs on the falling edge, model update just
        // before the rising edge.
        initial begin
            int seq;
            int phase;
            int sz;
            logic rdy;
            seq = 1;
            rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            memtoregin = '0; regwrin = 0; finin = 0; regdstmuxin = '0;
            aluoutin = '0; dmdatain = '0; pcnextin = '0;
            negativein = 0; insin = '0;
            for (int c = 0; c < NCYC; c++) begin
                @(negedge clk);
                phase = (c / 50) % 4;
                rst   = (c < 2) || ($urandom % 250 == 0);
                flush = (phase == 3) ? ($urandom % 6 == 0)
                                     : ($urandom % 40 == 0);
                case (phase)
                    0: begin in_valid = 1; out_ready = 1; end
                    1: begin in_valid = 1; out_ready = (c % 8) >= 5; end
                    default: begin
                        in_valid  = $urandom % 2;
                        out_ready = $urandom % 2;
                    end
                endcase
                memtoregin  = 2'($urandom);
                regwrin     = 1'($urandom);
                finin       = 1'($urandom);
                regdstmuxin = ($urandom % 4 == 0) ? '0 : RW'($urandom);
                aluoutin    = (phase == 0) ? DW'(seq) : $urandom;
                dmdatain    = $urandom;
                pcnextin    = $urandom;
                negativein  = 1'($urandom);
                insin       = $urandom;
                seq++;
                sz  = q.size();
                rdy = SK ? (sz < 2) : (sz == 0 || out_ready);
                acc_pend = in_valid && rdy && !rst && !flush;
                pend = '{memtoregin, regwrin, finin, regdstmuxin,
                         aluoutin, dmdatain, pcnextin, negativein, insin};
                #4;
                if (rst) begin
                    q.delete();
                    zero_ok = 1'b1;
                end else if (flush) begin
                    q.delete();
                end else if (acc_pend) begin
                    q.push_back(pend);
                    zero_ok = 1'b0;
                end
            end
            done++;
        end

        // Monitor: compares the presented head and handshake state against
        // the model, popping the model when WB consumes.
        initial begin
            ent_t e;
            int sz;
            @(posedge clk);
            forever begin
                @(negedge clk);
                #3;
                sz = q.size();
                chk("count", SK, 64'(count), 64'(sz));
                chk("out_valid", SK, 64'(out_valid), 64'(sz != 0));
                chk("in_ready", SK, 64'(in_ready),
                    64'(SK ? (sz < 2) : (sz == 0 || out_ready)));
                if (sz != 0) begin
                    e = q[0];
                    chk("memtoreg", SK, 64'(memtoregout), 64'(e.m2r));
                    chk("regwr", SK, 64'(regwrout), 64'(e.rw));
                    chk("fin", SK, 64'(finout), 64'(e.fin));
                    chk("regdst", SK, 64'(regdstmuxout), 64'(e.rd));
                    chk("aluout", SK, 64'(aluoutout), 64'(e.alu));
                    chk("dmdata", SK, 64'(dmdataout), 64'(e.dm));
                    chk("pcnext", SK, 64'(pcnextout), 64'(e.pc));
                    chk("negative", SK, 64'(negativeout), 64'(e.neg));
                    chk("ins", SK, 64'(insout), 64'(e.ins));
                    chk("wbdata", SK, 64'(wbdata), 64'(exp_wb(e)));
                    chk("fwd_en", SK, 64'(fwd_en),
                        64'(e.rw && e.rd != 0));
                    chk("fwd_reg", SK, 64'(fwd_reg), 64'(e.rd));
                    chk("fwd_data", SK, 64'(fwd_data), 64'(exp_wb(e)));
                    if (out_ready) void'(q.pop_front());
                end else begin
                    chk("fwd_en_idle", SK, 64'(fwd_en), 64'd0);
                    if (zero_ok) begin
                        chk("rst_alu", SK, 64'(aluoutout), 64'd0);
                        chk("rst_dm", SK, 64'(dmdataout), 64'd0);
                        chk("rst_pc", SK, 64'(pcnextout), 64'd0);
                        chk("rst_wb", SK, 64'(wbdata), 64'd0);
                        chk("rst_ins", SK, 64'(insout), 64'd0);
                        chk("rst_ctl", SK,
                            64'({memtoregout, regwrout, finout,
                                 regdstmuxout, negativeout}), 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        wait (done == 2);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
